// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its
// read-forwarding muxes.
package regfile_wb_arbiter_pkg;

    localparam int         WB_WIDTH      = 32;
    localparam int         RF_READ_PORTS = 6;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    typedef struct packed {
        logic                valid;
        logic [4:0]          addr;
        logic [WB_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Even registers live in bank 0 (write port 0), odd ones in bank 1.
    function automatic logic bank_of(input logic [4:0] addr);
        return addr[0];
    endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port's correction: r0 reads as zero, a deferred write is forwarded,
// otherwise the raw register-file value passes through.
module regfile_fwd_mux
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       i_ra,
    input  logic [WIDTH-1:0] i_rf_rd,
    input  logic             i_pend_valid,
    input  logic [4:0]       i_pend_addr,
    input  logic [WIDTH-1:0] i_pend_data,
    output logic [WIDTH-1:0] o_rd
);

    // Zero / pending / raw priority select.
    always_comb begin
        o_rd = i_rf_rd;
        if (i_ra == REG_ZERO) begin
            o_rd = '0;
        end else if (i_pend_valid && (i_ra == i_pend_addr)) begin
            o_rd = i_pend_data;
        end else begin
            o_rd = i_rf_rd;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter_chk.sv
// Bank-parity checks on the register-file write ports.
module regfile_wb_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic i_we0,
    input logic i_we1,
    input logic i_wa0_bank,
    input logic i_wa1_bank
);

    a_port0_even: assert property (@(posedge clk) disable iff (rst) i_we0 |-> !i_wa0_bank);
    a_port1_odd:  assert property (@(posedge clk) disable iff (rst) i_we1 |-> i_wa1_bank);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Dual writeback arbiter in front of the banked register file: resolves even/odd
// bank conflicts by deferring the younger write one cycle and forwards it to reads.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [1:0]                                 req_valid_i,
    input  logic [1:0][4:0]                            req_addr_i,
    input  logic [1:0][WIDTH-1:0]                      req_data_i,
    output logic                                       req_ready_o,
    output logic [4:0]                                 wa0_o,
    output logic [4:0]                                 wa1_o,
    output logic                                       we0_o,
    output logic                                       we1_o,
    output logic [WIDTH-1:0]                           wd0_o,
    output logic [WIDTH-1:0]                           wd1_o,
    input  logic [RF_READ_PORTS-1:0][4:0]              ra_i,
    input  logic [RF_READ_PORTS-1:0][WIDTH-1:0]        rf_rd_i,
    output logic [RF_READ_PORTS-1:0][WIDTH-1:0]        rd_o,
    output logic [CNT_W-1:0]                           stall_cnt_o
);

    state_t           r_state;
    logic [4:0]       r_pend_addr;
    logic [WIDTH-1:0] r_pend_data;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t               w_state_nxt;
    wb_req_t [1:0]        w_req;
    logic                 w_pend_valid;
    logic                 w_both;
    logic                 w_same;
    logic                 w_conflict;
    logic                 w_capture;
    logic [1:0]           w_issue;
    logic [1:0]           w_we;
    logic [1:0][4:0]      w_wa;
    logic [1:0][WIDTH-1:0] w_wd;

    assign w_pend_valid = (r_state == ST_DRAIN);

    // Mask r0 writes and classify the incoming pair.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < 2; i++) begin
            w_req[i].valid = req_valid_i[i] && (req_addr_i[i] != REG_ZERO);
            w_req[i].addr  = req_addr_i[i];
            w_req[i].data  = WB_WIDTH'(req_data_i[i]);
        end
        w_both     = w_req[0].valid && w_req[1].valid;
        w_same     = (w_req[0].addr == w_req[1].addr);
        w_conflict = w_both && !w_same &&
                     (bank_of(w_req[0].addr) == bank_of(w_req[1].addr));
    end

    // Next state and write-port steering.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_issue     = 2'b00;
        w_we        = 2'b00;
        w_wa        = '0;
        w_wd        = '0;
        case (r_state)
            ST_IDLE: begin
                // Same-address pairs squash the older write; conflicts defer the younger.
                w_issue[0] = w_req[0].valid && !(w_both && w_same);
                w_issue[1] = w_req[1].valid && !w_conflict;
                w_capture  = w_conflict;
                w_state_nxt = w_conflict ? ST_DRAIN : ST_IDLE;
                for (int p = 0; p < 2; p++) begin
                    if (w_issue[0] && (bank_of(w_req[0].addr) == 1'(p))) begin
                        w_we[p] = 1'b1;
                        w_wa[p] = w_req[0].addr;
                        w_wd[p] = WIDTH'(w_req[0].data);
                    end else if (w_issue[1] && (bank_of(w_req[1].addr) == 1'(p))) begin
                        w_we[p] = 1'b1;
                        w_wa[p] = w_req[1].addr;
                        w_wd[p] = WIDTH'(w_req[1].data);
                    end else begin
                        w_we[p] = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
                for (int p = 0; p < 2; p++) begin
                    if (!rst && (bank_of(r_pend_addr) == 1'(p))) begin
                        w_we[p] = 1'b1;
                        w_wa[p] = r_pend_addr;
                        w_wd[p] = r_pend_data;
                    end else begin
                        w_we[p] = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pending slot and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pend_addr <= REG_ZERO;
            r_pend_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_pend_addr <= w_req[1].addr;
                r_pend_data <= WIDTH'(w_req[1].data);
            end else begin
                r_pend_addr <= r_pend_addr;
                r_pend_data <= r_pend_data;
            end
            if (w_pend_valid && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign req_ready_o = rst || !w_pend_valid;
    assign stall_cnt_o = rst ? '0 : r_stall_cnt;
    assign we0_o = w_we[0];
    assign we1_o = w_we[1];
    assign wa0_o = w_wa[0];
    assign wa1_o = w_wa[1];
    assign wd0_o = w_wd[0];
    assign wd1_o = w_wd[1];

    for (genvar k = 0; k < RF_READ_PORTS; k++) begin : g_fwd
        regfile_fwd_mux #(.WIDTH(WIDTH)) u_fwd (
            .i_ra        (ra_i[k]),
            .i_rf_rd     (rf_rd_i[k]),
            .i_pend_valid(w_pend_valid),
            .i_pend_addr (r_pend_addr),
            .i_pend_data (r_pend_data),
            .o_rd        (rd_o[k])
        );
    end

endmodule
